// File: rtl/fp_classify_pipe.sv
// -----------------------------------------------------------------------------
// fp_classify_pipe
//
// Two-stage pipelined IEEE-754 operand classifier with valid/ready handshakes
// on both sides. Each accepted word is decoded into a 3-bit class code, its
// sign, and a "special" flag (set for every class except Normal). Special
// operands are steered to the FP bypass path by the consumer of this block.
//
// Class codes: 0 Zero, 1 Normal, 2 +Inf, 3 -Inf, 4 qNaN, 5 sNaN, 6 Subnormal.
// Code 7 is never produced.
//
// Parameters:
//   EXP_W  exponent field width (8 single, 11 double, 5 half)
//   MAN_W  mantissa field width (23 single, 52 double, 10 half)
//   CNT_W  width of the saturating class event counters
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          synchronous active-high reset
//   in_data      operand {sign, exponent, mantissa}
//   in_valid     operand present
//   in_ready     operand accepted this cycle (combinational from pipe state)
//   out_class    class code of the delivered result
//   out_sign     sign of the delivered result
//   out_special  1 for every class except Normal
//   out_valid    result present
//   out_ready    downstream accepts the result
//   cnt_clr      synchronous clear of the event counters (wins over increment)
//   cnt_special  number of special results delivered
//   cnt_nan      number of qNaN/sNaN results delivered
//   cnt_total    number of results delivered
//
// Build option:
//   FP_CLASS_CNT_EN  when defined, the three counters are built. When not
//                    defined, the counter outputs are tied to 0 and cnt_clr is
//                    ignored; the port list is identical in both builds.
// -----------------------------------------------------------------------------
module fp_classify_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2:0]               out_class,
  output logic                     out_sign,
  output logic                     out_special,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         cnt_special,
  output logic [CNT_W-1:0]         cnt_nan,
  output logic [CNT_W-1:0]         cnt_total
);

  localparam int W = EXP_W + MAN_W + 1;

  typedef enum logic [2:0] {
    CLS_ZERO      = 3'd0,
    CLS_NORMAL    = 3'd1,
    CLS_INF_POS   = 3'd2,
    CLS_INF_NEG   = 3'd3,
    CLS_QNAN      = 3'd4,
    CLS_SNAN      = 3'd5,
    CLS_SUBNORMAL = 3'd6
  } fp_class_e;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;

  assign in_sign = in_data[W-1];
  assign in_exp  = in_data[W-2 -: EXP_W];
  assign in_man  = in_data[MAN_W-1:0];

  // ---------------------------------------------------------------------------
  // Handshake / advance conditions
  // ---------------------------------------------------------------------------
  logic v1, v2;
  logic s1_adv, s2_adv;

  // A stage may load when it is empty or when its content moves on this cycle.
  // Ready therefore ripples back combinationally and the pipe has no bubbles.
  assign s2_adv    = !v2 || out_ready;
  assign s1_adv    = !v1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = v2;

  // ---------------------------------------------------------------------------
  // Stage 1: reduce the operand to the few flags the decode needs
  // ---------------------------------------------------------------------------
  logic s1_sign, s1_exp_zero, s1_exp_ones, s1_man_zero, s1_man_msb;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the flag registers are reset along with the valid bit; they are
      // few and it keeps the pipe free of X after reset in simulation.
      v1          <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp_zero <= 1'b0;
      s1_exp_ones <= 1'b0;
      s1_man_zero <= 1'b0;
      s1_man_msb  <= 1'b0;
    end else if (s1_adv) begin
      v1 <= in_valid;
      // Data is only captured with a real transfer; idle cycles leave it alone.
      if (in_valid) begin
        s1_sign     <= in_sign;
        s1_exp_zero <= (in_exp == '0);
        s1_exp_ones <= (in_exp == '1);
        s1_man_zero <= (in_man == '0);
        s1_man_msb  <= in_man[MAN_W-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 decode
  // ---------------------------------------------------------------------------
  fp_class_e s2_class_d;

  // NOTE: the default assignment at the top covers every path, so this block
  // can never infer a latch.
  always_comb begin
    s2_class_d = CLS_NORMAL;
    if (s1_exp_zero) begin
      s2_class_d = s1_man_zero ? CLS_ZERO : CLS_SUBNORMAL;
    end else if (s1_exp_ones) begin
      if (s1_man_zero) begin
        s2_class_d = s1_sign ? CLS_INF_NEG : CLS_INF_POS;
      end else begin
        // Quiet NaNs carry the mantissa MSB; signalling NaNs have it clear.
        s2_class_d = s1_man_msb ? CLS_QNAN : CLS_SNAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2          <= 1'b0;
      out_class   <= CLS_ZERO;
      out_sign    <= 1'b0;
      out_special <= 1'b0;
    end else if (s2_adv) begin
      v2 <= v1;
      // Output data only changes when a new result arrives, which keeps it
      // stable while the consumer stalls.
      if (v1) begin
        out_class   <= s2_class_d;
        out_sign    <= s1_sign;
        out_special <= (s2_class_d != CLS_NORMAL);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
`ifdef FP_CLASS_CNT_EN
  logic out_hs;
  logic out_is_nan;

  assign out_hs     = v2 && out_ready;
  assign out_is_nan = (out_class == CLS_QNAN) || (out_class == CLS_SNAN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_special <= '0;
      cnt_nan     <= '0;
      cnt_total   <= '0;
    end else if (out_hs) begin
      cnt_total <= sat_inc(cnt_total);
      if (out_special) cnt_special <= sat_inc(cnt_special);
      if (out_is_nan)  cnt_nan     <= sat_inc(cnt_nan);
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign cnt_special    = '0;
  assign cnt_nan        = '0;
  assign cnt_total      = '0;
`endif

endmodule

// File: doc/fp_classify_pipe.md
Name: fp_classify_pipe

Overview:
Parametrised, pipelined IEEE-754 operand classifier with valid/ready handshakes on input and output. It decodes one floating-point word per cycle into a class code and a special flag, with correct subnormal and quiet/signalling NaN separation. It sits at the front of the FP arithmetic units and steers special operands to the bypass path.

Parameters:
EXP_W, 8, exponent field width (8 = single, 11 = double, 5 = half)
MAN_W, 23, mantissa field width (23 = single, 52 = double, 10 = half)
CNT_W, 16, width of the class event counters (used only with FP_CLASS_CNT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_data  input  EXP_W+MAN_W+1  operand: sign at MSB, then exponent, then mantissa
in_valid  input  1  operand present
in_ready  output  1  block accepts the operand this cycle
out_class  output  3  class code
out_sign  output  1  sign bit of the classified operand
out_special  output  1  1 for every class except Normal
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
cnt_clr  input  1  synchronous clear of the event counters
cnt_special  output  CNT_W  count of special results delivered
cnt_nan  output  CNT_W  count of NaN results delivered
cnt_total  output  CNT_W  count of all results delivered

Behaviour:
- Class codes: 0 Zero, 1 Normal, 2 Inf_pos, 3 Inf_neg, 4 qNaN, 5 sNaN, 6 Subnormal, 7 unused (never produced).
- Decode (E = exponent, M = mantissa):
  - E = 0, M = 0 -> Zero, either sign.
  - E = 0, M != 0 -> Subnormal.
  - E all-ones, M = 0 -> Inf_pos if sign = 0, Inf_neg if sign = 1.
  - E all-ones, M != 0 -> qNaN if M MSB = 1, else sNaN.
  - Any other E -> Normal.
- Pipeline, two stages.
  - S1 registers the sign plus these flags: exp_zero, exp_ones, man_zero, man_msb.
  - S2 registers out_class, out_sign and out_special.
  - Latency is exactly 2 cycles from the input handshake to out_valid when there is no backpressure.
  - Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready are both high in the same cycle.
  - S2 advances when !v2 || out_ready.
  - S1 advances when !v1 || S2 advances.
  - in_ready = S1 advance condition. This is a combinational ready path; there are no bubbles under continuous flow.
  - out_valid = v2.
  - Output data is held stable while out_valid = 1 and out_ready = 0.
  - in_data is ignored while in_valid = 0.
  - Ordering is strictly in-order; no operand is dropped or duplicated.
- Reset:
  - v1 = 0, v2 = 0, out_class = 0, out_sign = 0, out_special = 0.
  - All counters = 0.
  - in_ready is 1 in the cycle after reset release.
  - Reset asserted mid-flow discards in-flight results without emitting them.
- Counters:
  - All three increment on the output handshake (out_valid && out_ready):
    - cnt_total on every result.
    - cnt_special when out_special = 1.
    - cnt_nan on class 4 or class 5.
  - Each counter saturates at 2^CNT_W-1.
  - cnt_clr has priority over a simultaneous increment: the counter reads 0 on the next cycle.

Optional Feature:
FP_CLASS_CNT_EN.
- Defined: the three counters and cnt_clr are implemented as described under Behaviour.
- Undefined: no counter registers are built. cnt_special, cnt_nan and cnt_total are driven constant 0, and cnt_clr is ignored. The ports remain in both builds so instantiations are identical.

Test Plan:
1. Defaults, FP_CLASS_CNT_EN defined, out_ready = 1. Stream 0x00000000, 0x80000000, 0x00000001, 0x7F800000, 0xFF800000, 0x7FC00000, 0x7F800001, 0x3F800000 back-to-back -> two cycles later, one result per cycle:
   - out_class = 0, 0, 6, 2, 3, 4, 5, 1
   - out_sign = 0, 1, 0, 0, 1, 0, 0, 0
   - out_special = 1, 1, 1, 1, 1, 1, 1, 0
   - afterwards cnt_total = 8, cnt_special = 7, cnt_nan = 2
2. Backpressure: send 0x3F800000 then 0x7F800000, hold out_ready = 0 for 5 cycles ->
   - out_valid stays 1 with class 1 held stable.
   - in_ready = 0 once both stages are full.
   - On release, classes 1 then 2 emerge in order.
3. EXP_W = 11, MAN_W = 52: operands 0x7FF0000000000000 -> class 2; 0x7FF8000000000000 -> class 4; 0x000FFFFFFFFFFFFF -> class 6.
4. EXP_W = 5, MAN_W = 10: operands 0x7C00 -> class 2; 0xFC00 -> class 3; 0x7D00 -> class 5; 0x3C00 -> class 1.
5. Reset mid-flow: accept 2 operands, assert rst for 1 cycle -> out_valid = 0 and counters = 0 on the following cycle, no stale result is emitted, and in_ready = 1.
6. Counter boundaries with CNT_W = 2:
   - 5 NaN results -> cnt_nan saturates at 3.
   - cnt_clr asserted in the same cycle as a NaN handshake -> cnt_nan = 0 next cycle.
   - Without FP_CLASS_CNT_EN, all counters read 0 throughout.
